// File: rtl/mc_bus_pkg.sv
// ---------------------------------------------------------------------------
// mc_bus_pkg
// Shared definitions for the MCU memory-controller bus responder:
//   - default bus widths
//   - responder FSM state encoding
//   - register address map seen by the MCU
// ---------------------------------------------------------------------------
package mc_bus_pkg;

   localparam int MC_DATA_WIDTH_DEF = 16;
   localparam int MC_ADD_WIDTH_DEF  = 6;

   // Register address map
   localparam logic [5:0] REG_IO_OD_OE    = 6'h00;  // od | oe
   localparam logic [5:0] REG_IO_HL_DIR   = 6'h01;  // hl | dir
   localparam logic [5:0] REG_SRAM_DATA   = 6'h02;
   localparam logic [5:0] REG_LA_SRAM_CTL = 6'h03;
   localparam logic [5:0] REG_LA_COUNT    = 6'h04;
   localparam logic [5:0] REG_PWM_0       = 6'h05;
   localparam logic [5:0] REG_PWM_1       = 6'h06;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ_REQ  = 3'd2,
      ST_READ_WAIT = 3'd3,
      ST_DRIVE     = 3'd4,
      ST_RECOVER   = 3'd5
   } mc_state_t;

endpackage

// File: rtl/mc_strobe_filter.sv
// ---------------------------------------------------------------------------
// mc_strobe_filter
// Two-flop synchronizer for one active-low bus strobe followed by a
// run-length qualifier.
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_strobe_n  raw active-low strobe from the pad
//   o_level     synchronized strobe level (1 = inactive)
//   o_qual      high while the strobe has been low for FILTER_CYCLES
//               consecutive synchronized cycles, including the current one
// ---------------------------------------------------------------------------
module mc_strobe_filter #(
   parameter int FILTER_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_strobe_n,
   output logic o_level,
   output logic o_qual
);
   import mc_bus_pkg::*;

   localparam int             CW     = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_SAT = CW'(FILTER_CYCLES);
   // The current low sample completes the run, so only FILTER_CYCLES-1
   // earlier low samples are required.
   localparam logic [CW-1:0]  CNT_TH  = CW'(FILTER_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic [CW-1:0] r_cnt;

   // Synchronizer; strobes idle high so reset to the inactive level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_strobe_n;
         r_sync <= r_meta;
      end
   end

   // Saturating count of consecutive synchronized-low cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_sync) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_level = r_sync;
   assign o_qual  = ~r_sync & (r_cnt >= CNT_TH);

endmodule

// File: rtl/mc_bus_responder.sv
// ---------------------------------------------------------------------------
// mc_bus_responder
// FPGA-side responder for the MCU asynchronous parallel memory bus.
// Each qualified MCU write pulse becomes one wr_en strobe; each qualified
// read pulse becomes one rd_en request whose returned data is driven back.
//   clock, reset            system clock, async active-high reset
//   mc_ce/mc_we/mc_oe       active-low bus strobes (asynchronous)
//   mc_add, mc_data_i       bus address / data from the pads
//   mc_data_o, mc_data_oe   read data and pad driver enable
//   wr_en/wr_addr/wr_data   one-cycle register-write strobe
//   rd_en/rd_addr           one-cycle read request; rd_data valid 1 cycle later
//   bus_err                 one-cycle pulse when we and oe qualify together
// ---------------------------------------------------------------------------
module mc_bus_responder
   import mc_bus_pkg::*;
#(
   parameter int MC_DATA_WIDTH = MC_DATA_WIDTH_DEF,
   parameter int MC_ADD_WIDTH  = MC_ADD_WIDTH_DEF,
   parameter int FILTER_CYCLES = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     mc_ce,
   input  logic                     mc_we,
   input  logic                     mc_oe,
   input  logic [MC_ADD_WIDTH-1:0]  mc_add,
   input  logic [MC_DATA_WIDTH-1:0] mc_data_i,
   output logic [MC_DATA_WIDTH-1:0] mc_data_o,
   output logic                     mc_data_oe,
   output logic                     wr_en,
   output logic [MC_ADD_WIDTH-1:0]  wr_addr,
   output logic [MC_DATA_WIDTH-1:0] wr_data,
   output logic                     rd_en,
   output logic [MC_ADD_WIDTH-1:0]  rd_addr,
   input  logic [MC_DATA_WIDTH-1:0] rd_data,
   output logic                     bus_err
);

   logic w_ce_s, w_ce_q;
   logic w_we_s, w_we_q;
   logic w_oe_s, w_oe_q;
   logic w_wr_q, w_rd_q;

   logic [MC_ADD_WIDTH-1:0]  r_add_m,  r_add_s;
   logic [MC_DATA_WIDTH-1:0] r_data_m, r_data_s;

   mc_state_t r_state;
   mc_state_t w_state_nxt;
   logic      w_wr_en_nxt;
   logic      w_rd_en_nxt;
   logic      w_err_nxt;
   logic      w_load_do;

   mc_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_ce_filt (
      .i_clk(clock), .i_rst(reset), .i_strobe_n(mc_ce),
      .o_level(w_ce_s), .o_qual(w_ce_q)
   );

   mc_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_we_filt (
      .i_clk(clock), .i_rst(reset), .i_strobe_n(mc_we),
      .o_level(w_we_s), .o_qual(w_we_q)
   );

   mc_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_oe_filt (
      .i_clk(clock), .i_rst(reset), .i_strobe_n(mc_oe),
      .o_level(w_oe_s), .o_qual(w_oe_q)
   );

   // A strobe only counts while chip enable is also qualified.
   assign w_wr_q = w_ce_q & w_we_q;
   assign w_rd_q = w_ce_q & w_oe_q;

   // Address/data synchronizers; sampled values are only used once the
   // strobes have qualified, long after these have settled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_add_m  <= '0;
         r_add_s  <= '0;
         r_data_m <= '0;
         r_data_s <= '0;
      end else begin
         r_add_m  <= mc_add;
         r_add_s  <= r_add_m;
         r_data_m <= mc_data_i;
         r_data_s <= r_data_m;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en_nxt = 1'b0;
      w_rd_en_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_load_do   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_q && w_rd_q) begin
               w_state_nxt = ST_RECOVER;
               w_err_nxt   = 1'b1;
            end else if (w_wr_q) begin
               w_state_nxt = ST_WRITE;
               w_wr_en_nxt = 1'b1;
            end else if (w_rd_q) begin
               w_state_nxt = ST_READ_REQ;
               w_rd_en_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            // Write already committed on entry; just wait out the pulse.
            if (w_we_s || w_ce_s) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_READ_REQ: begin
            w_state_nxt = ST_READ_WAIT;
         end
         ST_READ_WAIT: begin
            w_state_nxt = ST_DRIVE;
            w_load_do   = 1'b1;
         end
         ST_DRIVE: begin
            if (w_oe_s || w_ce_s) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_RECOVER: begin
            if (w_we_s && w_oe_s) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RECOVER;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register and registered strobes/payloads.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         bus_err   <= 1'b0;
         mc_data_o <= '0;
      end else begin
         r_state <= w_state_nxt;
         wr_en   <= w_wr_en_nxt;
         rd_en   <= w_rd_en_nxt;
         bus_err <= w_err_nxt;
         if (w_wr_en_nxt) begin
            wr_addr <= r_add_s;
            wr_data <= r_data_s;
         end else begin
            wr_addr <= wr_addr;
            wr_data <= wr_data;
         end
         if (w_rd_en_nxt) begin
            rd_addr <= r_add_s;
         end else begin
            rd_addr <= rd_addr;
         end
         if (w_load_do) begin
            mc_data_o <= rd_data;
         end else begin
            mc_data_o <= mc_data_o;
         end
      end
   end

   // Driver enable releases as soon as the synchronized oe/ce goes high,
   // without waiting for the state register, and clears with async reset.
   assign mc_data_oe = (r_state == ST_DRIVE) & ~w_oe_s & ~w_ce_s;

endmodule

// File: doc/mc_bus_responder.md
# mc_bus_responder

FPGA-side responder for the MCU's asynchronous 16-bit parallel memory-controller bus (active-low `mc_ce`/`mc_we`/`mc_oe`, 6-bit address). It synchronizes and deglitches the bus strobes, and converts each MCU write pulse into a single-cycle register-write strobe. Each MCU read pulse becomes a single-cycle read request whose returned data is driven back onto the bus. It sits between the top-level `mc_*` pins and the register bank and peripheral blocks (IO config, PWM, LA, SRAM).

## Interface
- `MC_DATA_WIDTH`, 16, bus data width
- `MC_ADD_WIDTH`, 6, bus address width
- `FILTER_CYCLES`, 2, consecutive synchronized-low samples required to qualify a strobe (≥1)

- `clock` in 1 system clock; all logic on rising edge
- `reset` in 1 asynchronous, active-high reset
- `mc_ce` in 1 chip enable, active low
- `mc_we` in 1 write strobe, active low
- `mc_oe` in 1 output-enable / read strobe, active low
- `mc_add` in MC_ADD_WIDTH bus address
- `mc_data_i` in MC_DATA_WIDTH bus data from pad
- `mc_data_o` out MC_DATA_WIDTH bus data to pad
- `mc_data_oe` out 1 pad driver enable; top builds the tri-state
- `wr_en` out 1 one-cycle register-write strobe
- `wr_addr` out MC_ADD_WIDTH write address, valid with `wr_en`
- `wr_data` out MC_DATA_WIDTH write data, valid with `wr_en`
- `rd_en` out 1 one-cycle read request, which may pop FIFOs
- `rd_addr` out MC_ADD_WIDTH read address, held until next request
- `rd_data` in MC_DATA_WIDTH read data, valid exactly 1 cycle after `rd_en`
- `bus_err` out 1 one-cycle pulse on protocol violation

## Operation
- All `mc_*` inputs pass through two-flop synchronizers (`*_s`). Address and data are captured only from synchronized copies.
- Write qualification: the write is qualified after `mc_ce_s` low and `mc_we_s` low on FILTER_CYCLES consecutive cycles. The read strobe (`oe_q`) is qualified the same way using `mc_oe_s`. Any high sample restarts the count.
- FSM states:
  - IDLE
    - `we_q` only → WRITE
    - `oe_q` only → READ_REQ
    - `we_q` and `oe_q` in the same cycle → RECOVER, with a one-cycle `bus_err` pulse and no write or read issued
  - WRITE
    - On entry, pulse `wr_en` for one cycle with the `mc_add_s`/`mc_data_i_s` values captured at qualification.
    - Then wait for `mc_we_s` high → IDLE.
    - `mc_ce_s` rising during WRITE → IDLE; the write is already committed.
  - READ_REQ
    - Pulse `rd_en` with `rd_addr` = `mc_add_s` → READ_WAIT.
  - READ_WAIT
    - Latch `rd_data` into `mc_data_o` → DRIVE.
  - DRIVE
    - `mc_data_oe`=1.
    - Leave when `mc_oe_s`=1 or `mc_ce_s`=1: `mc_data_oe` drops in the same cycle (unfiltered) → IDLE.
  - RECOVER
    - Wait until `mc_we_s`=1 and `mc_oe_s`=1 → IDLE.
- Exactly one `wr_en` per write pulse and one `rd_en` per read pulse, regardless of pulse length.
- A `mc_we` falling edge during DRIVE is ignored until IDLE. The filter keeps counting, so a write still low on return to IDLE is qualified immediately.

## Timing
- Reset values: all outputs 0, FSM IDLE, filter counters 0, synchronizers 1 for strobes and 0 for address/data.
- Reset asserted mid-operation: `mc_data_oe` drops asynchronously, and a pending `rd_en`/`wr_en` is lost.
- Write latency: `mc_we` fall to `wr_en` high is 2 (sync) + FILTER_CYCLES clocks (default 4). `wr_en` width is 1.
- Read latency:
  - `mc_oe` fall to `rd_en` is 2 + FILTER_CYCLES clocks.
  - `rd_en` to `mc_data_oe` high is 2 clocks.
  - Default: 6 clocks from `mc_oe` fall to driven data.
- Read release: `mc_oe` rise to `mc_data_oe` low is 2 clocks.
- Minimum MCU pulse width is FILTER_CYCLES + 4 clocks for reads and FILTER_CYCLES + 1 clocks for writes. Shorter read pulses give a truncated drive window; this is permitted, and `rd_en` still fires if the pulse qualified.
- A pulse shorter than FILTER_CYCLES synchronized cycles produces no strobe.

## Structure
- Shared package `mc_bus_pkg`: FSM state enum, `MC_DATA_WIDTH`/`MC_ADD_WIDTH` defaults, and register address constants. The register address map is 0x00 od|oe, 0x01 hl|dir, 0x02 SRAM data, 0x03 LA/SRAM control, 0x04 LA count, 0x05–0x06 PWM.
- One sub-module `mc_strobe_filter`: a 2-flop synchronizer plus a FILTER_CYCLES run-length qualifier. It is instantiated three times, for ce, we and oe. Address and data use plain 2-flop registers.

## Test plan
- Write to 0x00 with data 0x00FF, `mc_we` low for 6 clocks → exactly one `wr_en` at clock 4 after the fall, with `wr_addr`=0x00 and `wr_data`=0x00FF. No `rd_en`.
- Read from 0x02 while `rd_data` returns 0xAA one cycle after `rd_en` → one `rd_en` with `rd_addr`=0x02. `mc_data_oe` goes high 6 clocks after the `mc_oe` fall with `mc_data_o`=0x00AA, and drops 2 clocks after the `mc_oe` rise. A second read with `rd_data` 0x55 returns 0x0055.
- 1-clock low glitch on `mc_we`, then on `mc_oe` → no `wr_en`, no `rd_en`, `mc_data_oe` stays 0.
- `mc_we` and `mc_oe` pulled low on the same clock → one `bus_err` pulse, no `wr_en`/`rd_en`. After both return high, a normal write to 0x05 with data 0x0001 succeeds.
- Read in progress, `mc_ce` driven high during DRIVE → `mc_data_oe` low 2 clocks later, FSM returns to IDLE.
- `reset` asserted during DRIVE → `mc_data_oe`=0 immediately, all outputs 0. After release, a write to 0x03 with data 0x0009 produces a correct `wr_en`.
